// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and colour width.
// Defaults for the generator; the top module may override each of them.
package vga_timing_pkg;

  localparam int unsigned COLOR_W = 8;
  localparam int unsigned CNT_W   = 10;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

  // Half-open range test [lo, hi) on a counter value.
  function automatic logic in_range(input logic [CNT_W-1:0] val,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock into a one-clock pixel enable every CLK_DIV clocks.
// First tick arrives CLK_DIV clocks after reset release.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_p_tick
);

  generate
    if (CLK_DIV <= 1) begin : g_bypass
      logic w_unused;
      assign w_unused = i_clk ^ i_rst;
      assign o_p_tick = 1'b1;
    end else begin : g_div
      localparam int unsigned     CntW    = $clog2(CLK_DIV);
      localparam logic [CntW-1:0] LastCnt = CntW'(CLK_DIV - 1);

      logic [CntW-1:0] r_tick_cnt;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_tick_cnt <= '0;
        end else if (r_tick_cnt == LastCnt) begin
          r_tick_cnt <= '0;
        end else begin
          r_tick_cnt <= r_tick_cnt + 1'b1;
        end
      end

      assign o_p_tick = (r_tick_cnt == LastCnt);
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: pixel counters, coordinate publication and a
// registered, blanked RGB/sync output stage with one pixel of latency.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = vga_timing_pkg::CLK_DIV,
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] color_in,
  output logic               p_tick,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               video_on,
  output logic               frame_end,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] rgb
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HLast       = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast       = CNT_W'(VTotal - 1);
  localparam logic [CNT_W-1:0] HActive     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActive     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncStart  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSyncEnd    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VSyncStart  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSyncEnd    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic               w_p_tick;
  logic               w_h_last;
  logic               w_v_last;
  logic               w_video_on;
  logic               w_hsync_act;
  logic               w_vsync_act;

  logic [CNT_W-1:0]   r_h_count;
  logic [CNT_W-1:0]   r_v_count;
  logic [COLOR_W-1:0] r_rgb;
  logic               r_hsync;
  logic               r_vsync;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .i_clk    (clk),
    .i_rst    (reset),
    .o_p_tick (w_p_tick)
  );

  assign w_h_last    = (r_h_count == HLast);
  assign w_v_last    = (r_v_count == VLast);
  assign w_video_on  = (r_h_count < HActive) && (r_v_count < VActive);
  assign w_hsync_act = in_range(r_h_count, HSyncStart, HSyncEnd);
  assign w_vsync_act = in_range(r_v_count, VSyncStart, VSyncEnd);

  // Horizontal and vertical wraps coincide on the last tick of the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (w_p_tick) begin
      if (w_h_last) begin
        r_h_count <= '0;
        r_v_count <= w_v_last ? '0 : r_v_count + 1'b1;
      end else begin
        r_h_count <= r_h_count + 1'b1;
      end
    end
  end

  // One pixel of latency keeps colour and sync aligned at the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_p_tick) begin
      r_rgb   <= w_video_on ? color_in : '0;
      r_hsync <= ~w_hsync_act;
      r_vsync <= ~w_vsync_act;
    end
  end

  assign p_tick    = w_p_tick;
  assign x         = r_h_count;
  assign y         = r_v_count;
  assign video_on  = w_video_on;
  assign frame_end = w_p_tick && w_h_last && w_v_last;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign rgb       = r_rgb;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen using a shrunk timing set so whole frames fit
// in a short run; a cycle model predicts counters and queues expected pin values.
module tb_vga_sync_gen;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned H_ACTIVE = 16;
  localparam int unsigned H_FP     = 2;
  localparam int unsigned H_SYNC   = 3;
  localparam int unsigned H_BP     = 3;
  localparam int unsigned V_ACTIVE = 8;
  localparam int unsigned V_FP     = 1;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 2;
  localparam int unsigned HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FRAME    = HT * VT * CLK_DIV;

  typedef struct {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } out_t;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] color_in = 8'h00;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       frame_end;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb;

  int     n_cmp   = 0;
  int     n_err   = 0;
  int     m_tick  = 0;
  int     m_h     = 0;
  int     m_v     = 0;
  int     mode    = 0;
  int     fe_cnt  = 0;
  longint cyc     = 0;
  longint last_fe = -1;
  out_t   sb_q[$];
  out_t   cur     = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1};

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .color_in  (color_in),
    .p_tick    (p_tick),
    .x         (x),
    .y         (y),
    .video_on  (video_on),
    .frame_end (frame_end),
    .hsync     (hsync),
    .vsync     (vsync),
    .rgb       (rgb)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pattern(input int h, input int v, input int md);
    logic [31:0] hv;
    logic [31:0] vv;
    hv = h;
    vv = v;
    return (md == 0) ? 8'hE0 : {vv[2:0], hv[4:0]};
  endfunction

  // Cycle model: advances on each posedge and queues the expected registered outputs.
  always @(posedge clk) begin
    out_t e;
    cyc++;
    if (reset) begin
      m_tick  = 0;
      m_h     = 0;
      m_v     = 0;
      last_fe = -1;
      sb_q.delete();
      cur = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1};
    end else if (m_tick == CLK_DIV - 1) begin
      e.rgb = (m_h < H_ACTIVE && m_v < V_ACTIVE) ? color_in : 8'h00;
      e.hs  = !(m_h >= H_ACTIVE + H_FP && m_h < H_ACTIVE + H_FP + H_SYNC);
      e.vs  = !(m_v >= V_ACTIVE + V_FP && m_v < V_ACTIVE + V_FP + V_SYNC);
      sb_q.push_back(e);
      m_tick = 0;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end else begin
      m_tick++;
    end
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) cur = sb_q.pop_front();
    check_val("x", 32'(x), 32'(m_h));
    check_val("y", 32'(y), 32'(m_v));
    check_val("p_tick", 32'(p_tick), 32'(m_tick == CLK_DIV - 1));
    check_val("video_on", 32'(video_on), 32'(m_h < H_ACTIVE && m_v < V_ACTIVE));
    check_val("frame_end", 32'(frame_end),
              32'(m_tick == CLK_DIV - 1 && m_h == HT - 1 && m_v == VT - 1));
    check_val("rgb", 32'(rgb), 32'(cur.rgb));
    check_val("hsync", 32'(hsync), 32'(cur.hs));
    check_val("vsync", 32'(vsync), 32'(cur.vs));
    if (frame_end === 1'b1) begin
      fe_cnt++;
      if (last_fe >= 0) check_val("frame_spacing", 32'(cyc - last_fe), 32'(FRAME));
      last_fe = cyc;
    end
    color_in = pattern(m_h, m_v, mode);
  end

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // First frame with a constant colour, then a coordinate-dependent pattern.
    repeat (FRAME + 5) @(negedge clk);
    #1 mode = 1;
    repeat (FRAME + 5) @(negedge clk);
    check_val("frame_count_2", 32'(fe_cnt), 32'd2);

    // Mid-frame async reset, landing in the middle of a divider period.
    waited = 0;
    while (!(m_h == 10 && m_v == 5 && m_tick == 1) && waited < 2 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    check_val("wait_mid_frame", 32'(waited < 2 * FRAME), 32'd1);
    check_val("pre_reset_x", 32'(x), 32'd10);
    #1 reset = 1'b1;
    #2;
    check_val("async_x", 32'(x), 32'd0);
    check_val("async_y", 32'(y), 32'd0);
    check_val("async_rgb", 32'(rgb), 32'd0);
    check_val("async_hsync", 32'(hsync), 32'd1);
    check_val("async_vsync", 32'(vsync), 32'd1);
    check_val("async_p_tick", 32'(p_tick), 32'd0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    repeat (FRAME + 5) @(negedge clk);
    check_val("frame_count_3", 32'(fe_cnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Free-running 640x480@60 Hz VGA timing generator for the game display path.
- Divides the system clock into a pixel tick and runs the horizontal/vertical counters.
- Publishes the current pixel coordinate (x, y) to the renderers (title screen, ship, starfield).
- Takes back their merged 8-bit RRRGGGBB colour and drives blanked, registered RGB plus hsync/vsync to the pins. Sync and RGB are aligned to each other.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1; 4 gives 25 MHz from 100 MHz)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- color_in  in  8  merged renderer colour for the current (x,y)
- p_tick  out  1  one-clk pixel enable
- x  out  10  current horizontal count (0..H_TOTAL-1)
- y  out  10  current vertical count (0..V_TOTAL-1)
- video_on  out  1  current (x,y) is inside the active region
- frame_end  out  1  one-clk pulse on the last pixel tick of a frame
- hsync  out  1  horizontal sync, active low, aligned with rgb
- vsync  out  1  vertical sync, active low, aligned with rgb
- rgb  out  8  blanked output colour to the DAC pins

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port reset; it clears every register immediately, independent of clk.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Tick divider:
  - tick_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (tick_cnt == CLK_DIV-1), combinational from the register.
  - If CLK_DIV=1, p_tick is constantly 1.
  - Reset: tick_cnt=0, so the first p_tick comes CLK_DIV clocks after reset release.
- Counters (advance only on clk edges where p_tick=1):
  - h_count: h_count+1; wraps to 0 after H_TOTAL-1.
  - v_count: increments only when h_count wraps; wraps to 0 after V_TOTAL-1.
  - x=h_count and y=v_count, driven directly from the registers. Reset: 0, 0.
- video_on = (h_count < H_ACTIVE) && (v_count < V_ACTIVE), combinational. It is 1 immediately after reset, since (0,0) is visible.
- frame_end = p_tick && h_count==H_TOTAL-1 && v_count==V_TOTAL-1. Exactly one clk wide, once per frame. Game logic uses it to update positions.
- Output stage: registered, 1 pixel of latency, updated only on p_tick edges.
  - rgb <= video_on ? color_in : 8'h00.
  - hsync <= ~(h_count >= H_ACTIVE+H_FP && h_count < H_ACTIVE+H_FP+H_SYNC), i.e. low for h in 656..751.
  - vsync <= ~(v_count >= V_ACTIVE+V_FP && v_count < V_ACTIVE+V_FP+V_SYNC), i.e. low for v in 490..491.
  - Reset values: rgb=0, hsync=1, vsync=1 (inactive).
- Renderer timing: color_in must be a combinational function of x,y settled before the p_tick edge. Renderers with registered ROMs are out of scope.
- Boundaries:
  - The h and v wraps coincide on the frame_end tick; the next state is (0,0).
  - Between p_ticks all counters and outputs hold.
  - Reset asserted mid-frame zeroes the counters and forces sync inactive and rgb=0 at once.
  - After reset release, timing restarts from (0,0) with no partial frame.

Decomposition:
- vga_timing_pkg holds the timing constants (H_*, V_*, H_TOTAL, V_TOTAL, sync start/end) and the 8-bit colour width.
- One natural sub-module: pixel_tick_gen (tick divider; parameter CLK_DIV; outputs p_tick).
- The counters and output stage stay in vga_sync_gen.

Test Plan:
- Reset, then release with CLK_DIV=4 -> x=0, y=0, hsync=1, vsync=1, rgb=0; p_tick first high on the 4th clk; x=1 after that edge.
- Run one line -> x wraps from 799 to 0 and y becomes 1 on the same edge; exactly 800 p_ticks per line, 3200 clks.
- Sync timing -> hsync low on rgb-stage cycles following h=656..751 (96 ticks); vsync low for lines 490..491 (1600 ticks); the rest high.
- color_in held at 8'hE0 -> rgb=E0 for 640 ticks of each visible line and 0 during h>=640 and v>=480; rgb lags x by exactly 1 tick.
- Free run two frames -> frame_end pulses 1 clk wide, spaced 800*525*4 = 1,680,000 clks; the next coordinate is (0,0).
- Assert reset at x=300, y=200 for 3 clks, mid-CLK_DIV -> outputs go to reset values asynchronously; after release counting restarts from (0,0) and the first p_tick comes 4 clks later.
